rx_controller: RTL
==================

RX_CONTROLLER -- requirements
Module: rx_controller

Interface
REQ-001 SHALL have parameter NUM_DATA_BITS, default 8, meaning data bits per frame, sent LSB first.
REQ-002 SHALL have parameter TMR_BITS, default 4, meaning width of the bit-timer rollover value.
REQ-003 SHALL have parameter BIT_PERIOD, default 10, meaning clocks per bit; HALF_PERIOD = BIT_PERIOD/2, integer divide.
REQ-004 SHALL have port clk, input, 1, meaning the single system clock; every flop is rising-edge.
REQ-005 SHALL have port n_rst, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port serial_in, input, 1, meaning synchronized serial line; idle is 1.
REQ-007 SHALL have port start_bit_detected, input, 1, meaning a one-cycle pulse on a 1->0 line edge.
REQ-008 SHALL have port timer_rollover, input, 1, meaning a one-cycle pulse from the downstream bit-period flex counter.
REQ-009 SHALL have port data_read, input, 1, meaning the consumer acknowledges rx_data.
REQ-010 SHALL have port timer_clear, output, 1, meaning the clear input of the bit-period counter.
REQ-011 SHALL have port timer_enable, output, 1, meaning the count_enable of the bit-period counter.
REQ-012 SHALL have port timer_rollover_val, output, TMR_BITS, meaning the rollover value for the bit-period counter.
REQ-013 SHALL have port rx_data, output, NUM_DATA_BITS, meaning the last good received byte.
REQ-014 SHALL have port data_ready, output, 1, meaning rx_data holds an unread byte.
REQ-015 SHALL have port framing_error, output, 1, meaning the last frame's stop bit was 0.
REQ-016 SHALL have port overrun_error, output, 1, meaning an unread byte was overwritten.
REQ-017 SHALL have port rx_busy, output, 1, meaning the FSM is not in IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, START_WAIT, DATA, STOP and LOAD, held in registered state.
REQ-019 SHALL move IDLE->START_WAIT on start_bit_detected=1; start_bit_detected is ignored in every other state.
REQ-020 SHALL ignore timer_rollover in IDLE and LOAD.
REQ-021 SHALL handle timer_rollover in START_WAIT by sampling serial_in: 1 -> IDLE (false start, no flag change); 0 -> DATA.
REQ-022 SHALL handle each timer_rollover in DATA as: shift register <= {serial_in, shreg[NUM_DATA_BITS-1:1]}, and increment the bit counter.
REQ-023 SHALL size the bit counter at $clog2(NUM_DATA_BITS+1) bits, clear it on IDLE->START_WAIT, and move DATA->STOP on the rollover that makes the NUM_DATA_BITS-th shift.
REQ-024 SHALL handle timer_rollover in STOP by sampling serial_in: 1 -> LOAD; 0 -> IDLE with framing_error<=1, leaving rx_data and data_ready unchanged.
REQ-025 SHALL stay in LOAD for exactly one cycle and then go to IDLE; the edge leaving LOAD sets rx_data<=shreg and data_ready<=1.
REQ-026 SHALL set overrun_error<=1 on the LOAD edge if data_ready is 1 and data_read is 0 in that cycle.
REQ-027 SHALL clear data_ready and overrun_error on the edge after data_read=1; if this coincides with the LOAD edge, LOAD wins: data_ready=1, overrun_error=0.
REQ-028 SHALL clear framing_error on the IDLE->START_WAIT edge.
REQ-029 SHALL decode the timer outputs (Moore, combinational from state):
- timer_clear = 1 in IDLE only;
- timer_enable = 1 in START_WAIT, DATA and STOP;
- timer_rollover_val = HALF_PERIOD in IDLE/START_WAIT, else BIT_PERIOD.
REQ-030 SHALL drive rx_busy = (state != IDLE), combinationally.

Reset
REQ-031 SHALL, while n_rst=0, immediately force state IDLE, shift register 0, bit counter 0, rx_data 0, data_ready 0, framing_error 0 and overrun_error 0.
REQ-032 SHALL, during reset, give timer_clear=1, timer_enable=0, timer_rollover_val=HALF_PERIOD and rx_busy=0.
REQ-033 SHALL discard a partial frame on reset mid-operation, with no data_ready pulse after release.

Verification
REQ-034 SHALL be verified for reset in DATA after 3 bits: n_rst=0 -> same-time rx_busy=0, timer_clear=1, timer_rollover_val=5; after release data_ready stays 0.
REQ-035 SHALL be verified for a good frame: start, bits 1,0,1,0,0,1,0,1 (0xA5 LSB first), stop=1, with bench rollover pulses -> rx_data=0xA5, data_ready=1, framing_error=0, rx_busy=0.
REQ-036 SHALL be verified for a false start: serial_in=1 at the START_WAIT rollover -> IDLE next edge, data_ready stays 0, framing_error unchanged.
REQ-037 SHALL be verified for a bad stop: 0x3C frame with stop=0 -> framing_error=1, rx_data keeps its prior value; the next start pulse clears framing_error.
REQ-038 SHALL be verified for overrun: 0x3C then 0xC3 with no data_read -> rx_data=0xC3, overrun_error=1; a data_read pulse -> data_ready=0, overrun_error=0.
REQ-039 SHALL be verified with a real flex_counter (NUM_CNT_BITS=4) on clk/n_rst: 0x5A at BIT_PERIOD=10 -> rx_data=0x5A, with DATA-state rollovers exactly 10 clocks apart.

Source files
------------

// File: rtl/rx_controller.sv
// Receive-side framing controller for an async serial link: it sequences the external
// bit-period counter and assembles LSB-first frames into rx_data, with framing and overrun status.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | line idle, bit timer held clear, waiting for a start edge
// START_WAIT | half-period wait, then re-check that the start bit is still low
// DATA       | one serial_in sample per bit period into the shift register
// STOP       | sample the stop bit; a low stop bit is a framing error
// LOAD       | one cycle: publish shift register to rx_data and raise data_ready
module rx_controller #(
    parameter int NUM_DATA_BITS = 8,
    parameter int TMR_BITS      = 4,
    parameter int BIT_PERIOD    = 10
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     serial_in,
    input  logic                     start_bit_detected,
    input  logic                     timer_rollover,
    input  logic                     data_read,
    output logic                     timer_clear,
    output logic                     timer_enable,
    output logic [TMR_BITS-1:0]      timer_rollover_val,
    output logic [NUM_DATA_BITS-1:0] rx_data,
    output logic                     data_ready,
    output logic                     framing_error,
    output logic                     overrun_error,
    output logic                     rx_busy
);

    localparam int HALF_PERIOD = BIT_PERIOD / 2;
    localparam int CNT_W       = $clog2(NUM_DATA_BITS + 1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] START_WAIT = 3'd1;
    localparam logic [2:0] DATA       = 3'd2;
    localparam logic [2:0] STOP       = 3'd3;
    localparam logic [2:0] LOAD       = 3'd4;

    logic [2:0]               state;
    logic [NUM_DATA_BITS-1:0] shreg;
    logic [CNT_W-1:0]         bit_cnt;
    logic                     load;

    assign load = (state == LOAD);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            shreg         <= '0;
            bit_cnt       <= '0;
            rx_data       <= '0;
            framing_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_bit_detected) begin
                        state         <= START_WAIT;
                        bit_cnt       <= '0;
                        framing_error <= 1'b0;
                    end
                end
                START_WAIT: begin
                    // A line back high at mid start bit was a glitch, not a frame.
                    if (timer_rollover) begin
                        state <= serial_in ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (timer_rollover) begin
                        shreg   <= {serial_in, shreg[NUM_DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(NUM_DATA_BITS - 1)) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (timer_rollover) begin
                        if (serial_in) begin
                            state <= LOAD;
                        end else begin
                            state         <= IDLE;
                            framing_error <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state   <= IDLE;
                    rx_data <= shreg;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A fresh byte always wins over a same-cycle acknowledge of the old one.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
        end else if (load) begin
            data_ready <= 1'b1;
            if (data_read) begin
                overrun_error <= 1'b0;
            end else if (data_ready) begin
                overrun_error <= 1'b1;
            end
        end else if (data_read) begin
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
        end
    end

    always_comb begin
        timer_clear        = (state == IDLE);
        timer_enable       = (state == START_WAIT) || (state == DATA) || (state == STOP);
        timer_rollover_val = ((state == IDLE) || (state == START_WAIT)) ?
                             TMR_BITS'(HALF_PERIOD) : TMR_BITS'(BIT_PERIOD);
        rx_busy            = (state != IDLE);
    end

endmodule
